// File: rtl/biriscv_v_pkg.sv
// Shared definitions for the vector load writeback path: default widths,
// beat count and the writeback sequencer state encoding.
package biriscv_v_pkg;

   localparam int VLEN_DEFAULT   = 128;
   localparam int BEAT_W_DEFAULT = 32;
   localparam int BEATS          = VLEN_DEFAULT / BEAT_W_DEFAULT;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2
   } v_ldwb_state_t;

endpackage

// File: rtl/biriscv_v_load_wb.sv
// Vector load writeback sequencer: gathers BEAT_W-bit response beats into one
// VLEN-bit value and presents it for a single cycle on the register file write port.
module biriscv_v_load_wb
   import biriscv_v_pkg::*;
#(
   parameter int VLEN   = VLEN_DEFAULT,
   parameter int BEAT_W = BEAT_W_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   input  logic [4:0]        req_rd_i,
   output logic              req_ready_o,
   input  logic              mem_valid_i,
   input  logic [BEAT_W-1:0] mem_data_i,
   input  logic              mem_error_i,
   output logic              mem_ready_o,
   input  logic              flush_i,
   output logic [4:0]        rd0_o,
   output logic [VLEN-1:0]   rd0_value_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   // Handshake: a request transfers on a clock edge where req_valid_i and
   // req_ready_o are both high; a beat transfers where mem_valid_i and
   // mem_ready_o are both high. Neither ready depends on its own valid.

   localparam int NUM_BEATS = VLEN / BEAT_W;
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

   v_ldwb_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [VLEN-1:0]  buf_q, buf_d;
   logic [4:0]       rd_q, rd_d;
   logic             err_q, err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      rd_d    = rd_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_i && !flush_i) begin
               rd_d    = req_rd_i;
               buf_d   = '0;
               cnt_d   = '0;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (mem_valid_i) begin
               if (mem_error_i) begin
                  // The partially assembled value is dropped along with the beat.
                  buf_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  for (int k = 0; k < NUM_BEATS; k++) begin
                     if (cnt_q == CNT_W'(k)) begin
                        buf_d[k*BEAT_W +: BEAT_W] = mem_data_i;
                     end
                  end
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == LAST_BEAT) begin
                     state_d = WRITE;
                  end
               end
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
      end
   end

   assign req_ready_o = (state_q == IDLE) && !flush_i;
   assign mem_ready_o = (state_q == COLLECT) && !flush_i;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == WRITE);
   assign err_o       = err_q;
   // A flush arriving while the write is presented must still cancel it.
   assign rd0_o       = ((state_q == WRITE) && !flush_i) ? rd_q : 5'd0;
   assign rd0_value_o = (state_q == WRITE) ? buf_q : '0;

endmodule

// File: tb/tb_biriscv_v_load_wb.sv
// Bench for the vector load writeback sequencer: table-driven loads, directed
// flush/reset sequences and randomized loads against a beat-concatenation model.
module tb_biriscv_v_load_wb;

   logic         clk_i;
   logic         rst_i;
   logic         req_valid_i;
   logic [4:0]   req_rd_i;
   logic         req_ready_o;
   logic         mem_valid_i;
   logic [31:0]  mem_data_i;
   logic         mem_error_i;
   logic         mem_ready_o;
   logic         flush_i;
   logic [4:0]   rd0_o;
   logic [127:0] rd0_value_o;
   logic         busy_o;
   logic         done_o;
   logic         err_o;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [132:0] exp_q[$];
   logic [127:0] rf [32];

   typedef struct {
      logic [4:0]       rd;
      logic [3:0][31:0] b;
      int               gap;
      int               err_beat;
      logic [4:0]       exp_rd;
      logic [127:0]     exp_val;
      logic             exp_err;
   } vec_t;

   vec_t tbl [5];

   biriscv_v_load_wb #(.VLEN(128), .BEAT_W(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_rd_i    (req_rd_i),
      .req_ready_o (req_ready_o),
      .mem_valid_i (mem_valid_i),
      .mem_data_i  (mem_data_i),
      .mem_error_i (mem_error_i),
      .mem_ready_o (mem_ready_o),
      .flush_i     (flush_i),
      .rd0_o       (rd0_o),
      .rd0_value_o (rd0_value_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   // clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // register file model: captures the write port on the rising edge
   always @(posedge clk_i) begin
      if (rd0_o != 5'd0) rf[rd0_o] <= rd0_value_o;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard: every architectural write must match the oldest expected one
   always @(negedge clk_i) begin
      if (!rst_i && rd0_o != 5'd0) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got rd0=%0d value=%h required no write (t=%0t)",
                     rd0_o, rd0_value_o, $time);
         end else begin
            logic [132:0] e;
            e = exp_q.pop_front();
            chk("sb_write_rd", {123'd0, rd0_o}, {123'd0, e[132:128]});
            chk("sb_write_value", rd0_value_o, e[127:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic accept(input logic [4:0] rd);
      int t;
      t = 0;
      while (!req_ready_o && t < 20) begin
         step();
         t++;
      end
      chk("req_ready_before_accept", {127'd0, req_ready_o}, 128'd1);
      req_valid_i = 1'b1;
      req_rd_i    = rd;
      step();
      req_valid_i = 1'b0;
      req_rd_i    = 5'($urandom);
      chk("busy_after_accept", {127'd0, busy_o}, 128'd1);
   endtask

   task automatic send_beat(input logic [31:0] data, input logic err, input int gap);
      for (int g = 0; g < gap; g++) begin
         mem_error_i = 1'($urandom_range(0, 1));
         step();
      end
      chk("mem_ready_for_beat", {127'd0, mem_ready_o}, 128'd1);
      mem_valid_i = 1'b1;
      mem_data_i  = data;
      mem_error_i = err;
      step();
      mem_valid_i = 1'b0;
      mem_error_i = 1'b0;
      mem_data_i  = $urandom;
   endtask

   task automatic run_load(input vec_t v, input int gap_lo, input int gap_hi);
      accept(v.rd);
      for (int i = 0; i < 4; i++) begin
         send_beat(v.b[i], (i == v.err_beat), $urandom_range(gap_hi, gap_lo));
         if (i == v.err_beat) break;
      end
      if (v.exp_err) begin
         chk("err_pulse", {127'd0, err_o}, 128'd1);
         chk("err_no_write", {123'd0, rd0_o}, 128'd0);
         chk("err_idle", {127'd0, busy_o}, 128'd0);
         chk("err_no_done", {127'd0, done_o}, 128'd0);
      end else begin
         if (v.exp_rd != 5'd0) exp_q.push_back({v.exp_rd, v.exp_val});
         chk("write_done", {127'd0, done_o}, 128'd1);
         chk("write_rd", {123'd0, rd0_o}, {123'd0, v.exp_rd});
         chk("write_value", rd0_value_o, v.exp_val);
         chk("write_req_ready", {127'd0, req_ready_o}, 128'd0);
         chk("write_mem_ready", {127'd0, mem_ready_o}, 128'd0);
      end
      step();
      chk("after_done", {127'd0, done_o}, 128'd0);
      chk("after_err", {127'd0, err_o}, 128'd0);
      chk("after_busy", {127'd0, busy_o}, 128'd0);
      chk("after_rd0", {123'd0, rd0_o}, 128'd0);
      chk("after_value", rd0_value_o, 128'd0);
      if (!v.exp_err && v.exp_rd != 5'd0) chk("rf_read", rf[v.exp_rd], v.exp_val);
   endtask

   initial begin
      vec_t v;
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      req_rd_i    = 5'd0;
      mem_valid_i = 1'b0;
      mem_data_i  = 32'd0;
      mem_error_i = 1'b0;
      flush_i     = 1'b0;

      tbl[0] = '{rd: 5'd5, b: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                 gap: 0, err_beat: -1, exp_rd: 5'd5,
                 exp_val: 128'h44444444_33333333_22222222_11111111, exp_err: 1'b0};
      tbl[1] = '{rd: 5'd5, b: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                 gap: 2, err_beat: -1, exp_rd: 5'd5,
                 exp_val: 128'h44444444_33333333_22222222_11111111, exp_err: 1'b0};
      tbl[2] = '{rd: 5'd6, b: {32'hdead0003, 32'hdead0002, 32'hdead0001, 32'hdead0000},
                 gap: 0, err_beat: 2, exp_rd: 5'd0, exp_val: 128'd0, exp_err: 1'b1};
      tbl[3] = '{rd: 5'd7, b: {32'h77770003, 32'h77770002, 32'h77770001, 32'h77770000},
                 gap: 1, err_beat: -1, exp_rd: 5'd7,
                 exp_val: 128'h77770003_77770002_77770001_77770000, exp_err: 1'b0};
      tbl[4] = '{rd: 5'd0, b: {32'hcafe0003, 32'hcafe0002, 32'hcafe0001, 32'hcafe0000},
                 gap: 0, err_beat: -1, exp_rd: 5'd0,
                 exp_val: 128'hcafe0003_cafe0002_cafe0001_cafe0000, exp_err: 1'b0};

      // reset values
      #1;
      chk("rst_req_ready", {127'd0, req_ready_o}, 128'd1);
      chk("rst_mem_ready", {127'd0, mem_ready_o}, 128'd0);
      chk("rst_busy", {127'd0, busy_o}, 128'd0);
      chk("rst_done", {127'd0, done_o}, 128'd0);
      chk("rst_err", {127'd0, err_o}, 128'd0);
      chk("rst_rd0", {123'd0, rd0_o}, 128'd0);
      chk("rst_value", rd0_value_o, 128'd0);
      @(posedge clk_i);
      step();
      rst_i = 1'b0;
      step();

      // table-driven loads
      for (int i = 0; i < 5; i++) run_load(tbl[i], tbl[i].gap, tbl[i].gap);
      chk("rf_v5_kept", rf[5], 128'h44444444_33333333_22222222_11111111);

      // flush in COLLECT after beat 1
      accept(5'd9);
      send_beat(32'haaaa0000, 1'b0, 0);
      send_beat(32'haaaa0001, 1'b0, 0);
      flush_i = 1'b1;
      #1;
      chk("flush_mem_ready", {127'd0, mem_ready_o}, 128'd0);
      chk("flush_req_ready", {127'd0, req_ready_o}, 128'd0);
      step();
      flush_i = 1'b0;
      chk("flush_collect_idle", {127'd0, busy_o}, 128'd0);
      repeat (3) step();

      // flush while the write is presented
      accept(5'd10);
      for (int i = 0; i < 4; i++) send_beat(32'hbbbb0000 + i, 1'b0, 0);
      chk("flushw_done", {127'd0, done_o}, 128'd1);
      flush_i = 1'b1;
      #1;
      chk("flushw_rd0_suppressed", {123'd0, rd0_o}, 128'd0);
      step();
      flush_i = 1'b0;
      chk("flushw_idle", {127'd0, busy_o}, 128'd0);
      repeat (3) step();

      // asynchronous reset between edges in COLLECT
      accept(5'd3);
      send_beat(32'hcccc0000, 1'b0, 0);
      send_beat(32'hcccc0001, 1'b0, 0);
      #1;
      rst_i = 1'b1;
      #1;
      chk("arst_busy", {127'd0, busy_o}, 128'd0);
      chk("arst_req_ready", {127'd0, req_ready_o}, 128'd1);
      chk("arst_mem_ready", {127'd0, mem_ready_o}, 128'd0);
      chk("arst_rd0", {123'd0, rd0_o}, 128'd0);
      step();
      rst_i = 1'b0;
      for (int i = 2; i < 4; i++) begin
         mem_valid_i = 1'b1;
         mem_data_i  = 32'hcccc0000 + i;
         step();
      end
      mem_valid_i = 1'b0;
      repeat (2) step();
      chk("arst_no_resume", {127'd0, busy_o}, 128'd0);

      // randomized loads against the concatenation model
      for (int n = 0; n < 40; n++) begin
         v.rd = 5'($urandom_range(0, 31));
         for (int i = 0; i < 4; i++) v.b[i] = $urandom;
         v.gap      = 0;
         v.err_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
         v.exp_err  = (v.err_beat >= 0);
         v.exp_val  = 128'd0;
         for (int i = 0; i < 4; i++) v.exp_val = v.exp_val | (128'(v.b[i]) << (32 * i));
         v.exp_rd   = v.exp_err ? 5'd0 : v.rd;
         if (v.exp_err) v.exp_val = 128'd0;
         run_load(v, 0, 3);
      end

      repeat (2) step();
      chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/biriscv_v_load_wb.md
# biriscv_v_load_wb

Vector load writeback sequencer: collects `BEAT_W`-bit memory response beats for one vector load and assembles them into a `VLEN`-bit value. It then issues a single-cycle write to the vector register file's write port (`rd0`/`rd0_value`). It sits between the LSU response path and the 2-read/1-write vector register file. It is the producer for that file's write port.

## Interface
Parameters:
- `VLEN`, 128, vector register width in bits; must be a multiple of `BEAT_W`.
- `BEAT_W`, 32, memory response beat width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  1  new vector load request.
- `req_rd_i`  in  5  destination vector register.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `mem_valid_i`  in  1  response beat valid.
- `mem_data_i`  in  BEAT_W  response beat data.
- `mem_error_i`  in  1  bus error on this beat; qualified by `mem_valid_i`.
- `mem_ready_o`  out  1  beat accepted when high with `mem_valid_i`.
- `flush_i`  in  1  pipeline flush; aborts the in-flight load.
- `rd0_o`  out  5  register file write address; 0 means no write.
- `rd0_value_o`  out  VLEN  register file write data.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle pulse in the write cycle.
- `err_o`  out  1  one-cycle pulse when a load is aborted by `mem_error_i`.

## Operation
- `BEATS = VLEN/BEAT_W`, which is 4 at the defaults. Beat counter width is `$clog2(BEATS)`.
- **IDLE**
  - `req_ready_o=1`, `mem_ready_o=0`.
  - On `req_valid_i`: latch `req_rd_i`, clear the assembly buffer and beat counter, go to COLLECT.
- **COLLECT**
  - `req_ready_o=0`, `mem_ready_o=1`.
  - On a beat without error: write `mem_data_i` into buffer bits `[k*BEAT_W +: BEAT_W]`, where k is the beat counter (beat 0 lands in the LSBs), then increment k.
  - If this was beat `BEATS-1`, go to WRITE.
- **WRITE** (exactly one cycle)
  - `rd0_o` = latched rd, `rd0_value_o` = buffer, `done_o=1`.
  - Both ready outputs are 0. Next state is IDLE.
- Outside WRITE: `rd0_o=0` and `rd0_value_o=0`. The register file sees no write.
- `req_rd_i=0`: the load proceeds normally and consumes all beats. In WRITE, `rd0_o=0`, so no architectural write occurs, but `done_o` still pulses.
- `mem_error_i` with `mem_valid_i` in COLLECT: discard the beat and buffer, pulse `err_o` next cycle, return to IDLE. No write.
- `flush_i`: from COLLECT or WRITE, go to IDLE next cycle.
  - `mem_ready_o` and `req_ready_o` are forced to 0 while `flush_i` is high.
  - A write already being presented in WRITE is suppressed: `rd0_o` is forced to 0 combinationally.
  - `flush_i` in IDLE has no effect apart from blocking acceptance that cycle.
- Priority: `rst_i` > `flush_i` > `mem_error_i` > normal.
- `mem_valid_i` outside COLLECT is ignored. The LSU must not present beats that would not be accepted.

## Timing
- Reset values:
  - state IDLE, counter 0, buffer 0.
  - `rd0_o=0`, `rd0_value_o=0`.
  - `busy_o=0`, `done_o=0`, `err_o=0`.
  - `req_ready_o=1`, `mem_ready_o=0`.
- Reset asserted mid-load drops the load with no write.
- `rd0_o`, `rd0_value_o`, `done_o`, `err_o` are registered (state-decoded from flops). The exception is the flush suppression of `rd0_o`.
- Latency:
  - Request accepted at edge T gives COLLECT from T.
  - The last beat accepted at edge N gives WRITE during cycle N..N+1.
  - The register file captures on edge N+1; data is readable from the file after edge N+1.
- Minimum occupancy: 1 (accept) + BEATS + 1 (write) cycles, which is 6 at the defaults.
- There is no back-to-back request acceptance in WRITE.
- Beats may arrive with arbitrary gaps (`mem_valid_i` low); the counter holds.

## Structure
- Shared package `biriscv_v_pkg`:
  - `VLEN` default.
  - `BEAT_W` default.
  - State enum `v_ldwb_state_t` {IDLE, COLLECT, WRITE}.
  - Localparam `BEATS`.
- No sub-module. Buffer, counter and FSM are one always_ff block plus combinational output decode.
- Outputs connect directly to the register file's `rd0`/`rd0_value` inputs.

## Test plan
- **Basic load:** request rd=5, then beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
  - Expect exactly one cycle with `rd0_o=5` and `rd0_value_o=0x44444444_33333333_22222222_11111111`, `done_o=1`.
  - A read of v5 from the register file afterwards returns that value.
- **Gapped beats:** the same load with 2-cycle gaps between beats → identical write, occurring one cycle after the last beat.
- **Error on beat 2:**
  - Expect `err_o` pulse, `rd0_o` never nonzero, state IDLE.
  - A following clean load to rd=7 writes correctly, with no stale data from the aborted load.
- **Flush:** `flush_i` during COLLECT after beat 1, and separately during WRITE → no write in either case, `busy_o=0` the next cycle.
- **rd=0:** a load with rd=0 → all 4 beats consumed, `done_o` pulses, `rd0_o` stays 0.
- **Async reset:** assert `rst_i` mid-COLLECT between clock edges.
  - Outputs go to their reset values immediately.
  - No write follows after deassertion.
